l1_mw_dp_mem: RTL and testbench
===============================

Name: l1_mw_dp_mem

Overview:
- Parametrised multi-way, one-read/one-write storage array for the L1 caches. Used for tag, data and valid arrays.
- Holds WAYS independent ways of DEPTH x WIDTH. All ways are read in parallel. Writes are per-way, with byte enables.
- Built-in hardware clear sequencer writes INIT_VAL to every entry after reset and on a flush request. READY is low while the sweep runs.
- Optional write-to-read bypass for same-address collisions.

Parameters:
- WIDTH, 32: bits per way entry; must be a multiple of 8.
- DEPTH, 64: entries per way; any value >= 2, not necessarily a power of two.
- WAYS, 4: number of ways.
- INIT_VAL, 0: WIDTH-bit value written to every entry during a sweep.
- BYPASS, 1: 1 = a read colliding with a same-cycle write returns the new data; 0 = returns the old data.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- REN  in  1  read enable.
- RADDR  in  $clog2(DEPTH)  read index.
- RDATA  out  WAYS*WIDTH  all ways; way w occupies bits [w*WIDTH +: WIDTH].
- RVALID  out  1  RDATA valid; asserted one cycle after an accepted read.
- WEN  in  WAYS  one-hot or multi-hot way write enables.
- WADDR  in  $clog2(DEPTH)  write index.
- WBE  in  WIDTH/8  byte enables, common to all enabled ways.
- WDATA  in  WIDTH  write data.
- FLUSH  in  1  single-cycle request to re-clear the whole array.
- READY  out  1  array is usable.
- INIT_DONE  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset values: READY=0, RVALID=0, INIT_DONE=0, sweep counter=0, state=INIT. RDATA is 0 while RVALID=0.
- FSM states are INIT and RUN.
  - INIT: each cycle writes INIT_VAL to entry cnt in all ways, all bytes, then increments cnt.
  - On the cycle that cnt==DEPTH-1 is written: next state is RUN, cnt clears to 0, and INIT_DONE pulses in the first RUN cycle.
  - A sweep lasts exactly DEPTH cycles. READY rises in the cycle after the last sweep write.
- READY = (state==RUN).
- While in INIT:
  - External WEN and REN are ignored; their writes are dropped and their reads are not accepted.
  - RVALID stays 0.
  - FLUSH is ignored; the sweep does not restart.
- FLUSH sampled high in RUN: the next state is INIT with cnt=0.
  - A write in that same cycle is still performed, then overwritten later by the sweep.
  - A read in that same cycle still completes: RVALID=1 in the next cycle.
- Read, in RUN: REN=1 -> RDATA/RVALID valid on the next clock edge. Latency is 1; throughput is one read per cycle.
  - RDATA holds its last value while RVALID=0 after the first read. It returns to 0 only on reset.
- Write, in RUN, for each way w with WEN[w]=1: byte b of entry WADDR is updated from WDATA[8b+7:8b] iff WBE[b]=1. Bytes with WBE[b]=0 are unchanged.
- Collision (REN & |WEN & RADDR==WADDR in the same cycle):
  - BYPASS=1: for each written way, RDATA gives the merged value (new bytes where WBE=1, old bytes elsewhere). Unwritten ways return stored data.
  - Implementation: register a per-way/per-byte select plus WDATA; mux after the SRAM output.
  - BYPASS=0: all ways return pre-write data.
- Index range: RADDR/WADDR >= DEPTH is illegal in RUN. Add an assertion; no defined data.
- Reset mid-sweep or mid-operation: all state returns to reset values immediately, asynchronously, and a full sweep restarts.
- Storage is one sram_dp per way per byte lane (WAYS*WIDTH/8 instances, WIDTH 8 each):
  - Port A is read: WEA=0, ENA = REN & READY.
  - Port B is write: WEB=1, ENB = sweep | (WEN[w] & WBE[b] & READY).

Decomposition:
- Shared package l1_mem_pkg: FSM state encodings (INIT=1'b0, RUN=1'b1), byte width constant 8, and the collision-select record layout.
- One natural sub-module: l1_mem_clr_seq. It contains the INIT/RUN FSM, sweep counter, FLUSH handling, READY and INIT_DONE, and the write-port muxing of address/data/enable.
- The top module instantiates the sequencer, the sram_dp array via generate, and the bypass/merge logic.

Test Plan (WIDTH=32, DEPTH=16, WAYS=2, INIT_VAL=32'hA5A5A5A5, BYPASS=1):
- Release RST_N, count cycles -> READY=1 exactly 16 cycles after release, INIT_DONE pulses for 1 cycle; read all 16 indices -> every way reads A5A5A5A5 with RVALID one cycle after REN.
- Write WEN=2'b10, WADDR=3, WBE=4'b0011, WDATA=32'h11223344, then read 3 -> way1=A5A53344, way0=A5A5A5A5.
- Same cycle: REN, RADDR=5, WEN=2'b01, WADDR=5, WBE=4'hF, WDATA=32'hDEADBEEF -> next cycle way0=DEADBEEF (bypass), way1=A5A5A5A5; a repeat read also gives DEADBEEF.
- Write entries 0..15 with distinct values, pulse FLUSH -> READY=0 for 16 cycles, WEN/REN during the sweep are ignored (RVALID=0), then all entries read A5A5A5A5 and INIT_DONE pulses once.
- Assert RST_N=0 at sweep cycle 7 (and separately during RUN after writes) -> READY=0 immediately; after release the sweep takes a full 16 cycles and all data equals INIT_VAL.
- FLUSH asserted during an active sweep -> ignored; READY rises at the original 16-cycle point.

Source files
------------

// File: rtl/l1_mem_pkg.sv
// Shared types for the L1 multi-way array: sequencer state encoding and bypass lane record.
// No logic of its own; no latency, no backpressure.
package l1_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int BYTE_W = 8;

  // One entry per way/byte lane: take the registered write byte instead of the SRAM byte.
  typedef struct packed {
    logic              sel;
    logic [BYTE_W-1:0] dat;
  } byp_lane_t;

endpackage

// File: rtl/l1_mem_clr_seq.sv
// Clear sequencer: sweeps INIT_VAL through every entry after reset/flush, then steers external writes.
// Sweep takes DEPTH cycles; external traffic is dropped (not stalled) while READY is low.
module l1_mem_clr_seq
  import l1_mem_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter int                DEPTH    = 64,
  parameter int                WAYS     = 4,
  parameter logic [WIDTH-1:0]  INIT_VAL = '0,
  localparam int               AW       = $clog2(DEPTH),
  localparam int               NB       = WIDTH / BYTE_W
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 FLUSH,
  input  logic [WAYS-1:0]      WEN,
  input  logic [AW-1:0]        WADDR,
  input  logic [NB-1:0]        WBE,
  input  logic [WIDTH-1:0]     WDATA,
  output logic                 READY,
  output logic                 INIT_DONE,
  output logic [WAYS*NB-1:0]   WR_EN,
  output logic [AW-1:0]        WR_ADDR,
  output logic [WIDTH-1:0]     WR_DATA
);

  state_e        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_INIT;
      cnt       <= '0;
      READY     <= 1'b0;
      INIT_DONE <= 1'b0;
    end else begin
      INIT_DONE <= 1'b0;
      case (state)
        ST_INIT: begin
          if (cnt == AW'(DEPTH - 1)) begin
            state     <= ST_RUN;
            cnt       <= '0;
            READY     <= 1'b1;
            INIT_DONE <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        ST_RUN: begin
          if (FLUSH) begin
            state <= ST_INIT;
            cnt   <= '0;
            READY <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // During the sweep the write port belongs to the sequencer; external writes are dropped.
  always_comb begin
    WR_EN   = '0;
    WR_ADDR = WADDR;
    WR_DATA = WDATA;
    if (state == ST_INIT) begin
      WR_EN   = '1;
      WR_ADDR = cnt;
      WR_DATA = INIT_VAL;
    end else begin
      for (int w = 0; w < WAYS; w++)
        for (int b = 0; b < NB; b++)
          WR_EN[w*NB + b] = WEN[w] & WBE[b];
    end
  end

endmodule

// File: rtl/sram_dp.sv
// Synchronous dual-port RAM, read-first on both ports; DOA registered, reset to 0, holds when ENA=0.
// Read latency 1 cycle; accepts one access per port per cycle, no backpressure.
module sram_dp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                                     CLK,
  input  logic                                     RST_N,
  input  logic                                     ENA,
  input  logic                                     WEA,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] ADDRA,
  input  logic [WIDTH-1:0]                         DIA,
  output logic [WIDTH-1:0]                         DOA,
  input  logic                                     ENB,
  input  logic                                     WEB,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] ADDRB,
  input  logic [WIDTH-1:0]                         DIB
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (ENA && WEA) mem[ADDRA] <= DIA;
    if (ENB && WEB) mem[ADDRB] <= DIB;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   DOA <= '0;
    else if (ENA) DOA <= mem[ADDRA];
  end

endmodule

// File: rtl/l1_mw_dp_mem.sv
// Multi-way 1R1W L1 storage array with byte-enable writes, hardware clear sweep and optional write bypass.
// Read latency 1 cycle, one read and one write per cycle; REN/WEN are dropped while READY is low.
module l1_mw_dp_mem
  import l1_mem_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter int                DEPTH    = 64,
  parameter int                WAYS     = 4,
  parameter logic [WIDTH-1:0]  INIT_VAL = '0,
  parameter int                BYPASS   = 1,
  localparam int               AW       = $clog2(DEPTH),
  localparam int               NB       = WIDTH / BYTE_W
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    REN,
  input  logic [AW-1:0]           RADDR,
  output logic [WAYS*WIDTH-1:0]   RDATA,
  output logic                    RVALID,
  input  logic [WAYS-1:0]         WEN,
  input  logic [AW-1:0]           WADDR,
  input  logic [NB-1:0]           WBE,
  input  logic [WIDTH-1:0]        WDATA,
  input  logic                    FLUSH,
  output logic                    READY,
  output logic                    INIT_DONE
);

  localparam bit BYP_EN = (BYPASS != 0);

  logic [WAYS*NB-1:0] wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic               rd_acc;
  logic               addr_hit;

  l1_mem_clr_seq #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .WAYS     (WAYS),
    .INIT_VAL (INIT_VAL)
  ) u_clr_seq (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .FLUSH     (FLUSH),
    .WEN       (WEN),
    .WADDR     (WADDR),
    .WBE       (WBE),
    .WDATA     (WDATA),
    .READY     (READY),
    .INIT_DONE (INIT_DONE),
    .WR_EN     (wr_en),
    .WR_ADDR   (wr_addr),
    .WR_DATA   (wr_data)
  );

  assign rd_acc   = REN & READY;
  assign addr_hit = (RADDR == WADDR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) RVALID <= 1'b0;
    else        RVALID <= rd_acc;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    for (genvar b = 0; b < NB; b++) begin : g_lane
      logic [BYTE_W-1:0] ram_q;
      byp_lane_t         byp_q;

      sram_dp #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
      ) u_ram (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ENA   (rd_acc),
        .WEA   (1'b0),
        .ADDRA (RADDR),
        .DIA   ('0),
        .DOA   (ram_q),
        .ENB   (wr_en[w*NB + b]),
        .WEB   (1'b1),
        .ADDRB (wr_addr),
        .DIB   (wr_data[b*BYTE_W +: BYTE_W])
      );

      // SRAM reads old data on a collision; the registered write byte is muxed in afterwards.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          byp_q <= '0;
        end else if (rd_acc) begin
          byp_q.sel <= BYP_EN && addr_hit && WEN[w] && WBE[b];
          byp_q.dat <= WDATA[b*BYTE_W +: BYTE_W];
        end
      end

      assign RDATA[w*WIDTH + b*BYTE_W +: BYTE_W] = byp_q.sel ? byp_q.dat : ram_q;
    end
  end

  if (DEPTH < (1 << AW)) begin : g_idx_chk
    a_raddr_range: assert property (@(posedge CLK) disable iff (!RST_N)
      rd_acc |-> (int'(RADDR) < DEPTH));
    a_waddr_range: assert property (@(posedge CLK) disable iff (!RST_N)
      ((|WEN) && READY) |-> (int'(WADDR) < DEPTH));
  end

endmodule

// File: tb/tb_l1_mw_dp_mem.sv
// Directed bench for l1_mw_dp_mem: clear sweep, byte-enable writes, bypass, flush and reset corners.
module tb_l1_mw_dp_mem;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 16;
  localparam int          WAYS  = 2;
  localparam int          AW    = 4;
  localparam int          NB    = 4;
  localparam logic [31:0] IV    = 32'hA5A5A5A5;
  localparam int          NV    = 13;

  logic                  CLK   = 1'b0;
  logic                  RST_N = 1'b0;
  logic                  REN   = 1'b0;
  logic [AW-1:0]         RADDR = '0;
  logic [WAYS*WIDTH-1:0] RDATA;
  logic                  RVALID;
  logic [WAYS-1:0]       WEN   = '0;
  logic [AW-1:0]         WADDR = '0;
  logic [NB-1:0]         WBE   = '0;
  logic [WIDTH-1:0]      WDATA = '0;
  logic                  FLUSH = 1'b0;
  logic                  READY;
  logic                  INIT_DONE;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        ren;
    logic [3:0]  raddr;
    logic [1:0]  wen;
    logic [3:0]  waddr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic        exp_rv;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vt [NV];

  l1_mw_dp_mem #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .WAYS     (WAYS),
    .INIT_VAL (IV),
    .BYPASS   (1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REN       (REN),
    .RADDR     (RADDR),
    .RDATA     (RDATA),
    .RVALID    (RVALID),
    .WEN       (WEN),
    .WADDR     (WADDR),
    .WBE       (WBE),
    .WDATA     (WDATA),
    .FLUSH     (FLUSH),
    .READY     (READY),
    .INIT_DONE (INIT_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ren, input logic [3:0] raddr, input logic [1:0] wen,
                        input logic [3:0] waddr, input logic [3:0] wbe, input logic [31:0] wdata,
                        input logic flush);
    REN   = ren;
    RADDR = raddr;
    WEN   = wen;
    WADDR = waddr;
    WBE   = wbe;
    WDATA = wdata;
    FLUSH = flush;
  endtask

  task automatic idle();
    set_in(1'b0, 4'd0, 2'b00, 4'd0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs 20 cycles from sweep start, hammering REN/WEN during the sweep; WADDR trails the sweep pointer.
  task automatic run_sweep(input string tag, input bit flush_mid);
    int first = 0;
    int done  = 0;
    int rv    = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 15)
        set_in(1'b1, 4'(i), 2'b11, (i > 0) ? 4'(i - 1) : 4'd0, 4'hF, 32'hFFFFFFFF,
               flush_mid && (i == 5));
      else
        idle();
      step();
      if (INIT_DONE) done++;
      if (RVALID)    rv++;
      if (READY && first == 0) first = i + 1;
    end
    check({tag, "_ready_cycles"}, 64'(first), 64'd16);
    check({tag, "_init_done_pulses"}, 64'(done), 64'd1);
    check({tag, "_rvalid_in_sweep"}, 64'(rv), 64'd0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 4'(i), 2'b00, 4'd0, 4'h0, 32'h0, 1'b0);
      step();
      check($sformatf("%s_rvalid_%0d", tag, i), 64'(RVALID), 64'd1);
      check($sformatf("%s_rdata_%0d", tag, i), RDATA, {IV, IV});
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b0, 4'd0, 2'b10, 4'd3, 4'b0011, 32'h11223344, 1'b0, {IV, IV}};
    vt[1]  = '{1'b1, 4'd3, 2'b00, 4'd0, 4'h0,    32'h0,        1'b1, {32'hA5A53344, IV}};
    vt[2]  = '{1'b1, 4'd5, 2'b01, 4'd5, 4'hF,    32'hDEADBEEF, 1'b1, {IV, 32'hDEADBEEF}};
    vt[3]  = '{1'b1, 4'd5, 2'b00, 4'd0, 4'h0,    32'h0,        1'b1, {IV, 32'hDEADBEEF}};
    vt[4]  = '{1'b1, 4'd7, 2'b11, 4'd7, 4'b0101, 32'h12345678, 1'b1, {32'hA534A578, 32'hA534A578}};
    vt[5]  = '{1'b1, 4'd7, 2'b00, 4'd0, 4'h0,    32'h0,        1'b1, {32'hA534A578, 32'hA534A578}};
    vt[6]  = '{1'b1, 4'd3, 2'b01, 4'd4, 4'hF,    32'h0BADF00D, 1'b1, {32'hA5A53344, IV}};
    vt[7]  = '{1'b1, 4'd4, 2'b00, 4'd0, 4'h0,    32'h0,        1'b1, {IV, 32'h0BADF00D}};
    vt[8]  = '{1'b0, 4'd0, 2'b00, 4'd0, 4'h0,    32'h0,        1'b0, {IV, 32'h0BADF00D}};
    vt[9]  = '{1'b1, 4'd6, 2'b11, 4'd6, 4'h0,    32'hFFFFFFFF, 1'b1, {IV, IV}};
    vt[10] = '{1'b1, 4'd6, 2'b00, 4'd0, 4'h0,    32'h0,        1'b1, {IV, IV}};
    vt[11] = '{1'b1, 4'd2, 2'b01, 4'd2, 4'b1000, 32'hAB000000, 1'b1, {IV, 32'hABA5A5A5}};
    vt[12] = '{1'b1, 4'd2, 2'b00, 4'd0, 4'h0,    32'h0,        1'b1, {IV, 32'hABA5A5A5}};

    // Reset state
    idle();
    repeat (3) step();
    check("rst_ready", 64'(READY), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_init_done", 64'(INIT_DONE), 64'd0);
    check("rst_rdata", RDATA, 64'd0);

    RST_N = 1'b1;
    run_sweep("boot", 1'b0);
    read_all("boot");
    step();
    check("idle_rvalid", 64'(RVALID), 64'd0);
    check("idle_rdata_hold", RDATA, {IV, IV});

    for (int k = 0; k < NV; k++) begin
      set_in(vt[k].ren, vt[k].raddr, vt[k].wen, vt[k].waddr, vt[k].wbe, vt[k].wdata, 1'b0);
      step();
      check($sformatf("vec%0d_rvalid", k), 64'(RVALID), 64'(vt[k].exp_rv));
      check($sformatf("vec%0d_rdata", k), RDATA, vt[k].exp_rd);
      check($sformatf("vec%0d_ready", k), 64'(READY), 64'd1);
    end

    // Flush: fill with distinct data, read in the flush cycle still completes
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, 4'd0, 2'b11, 4'(i), 4'hF, 32'hC0DE0000 + 32'(i), 1'b0);
      step();
    end
    set_in(1'b1, 4'd9, 2'b00, 4'd0, 4'h0, 32'h0, 1'b0);
    step();
    check("fill_rdata_9", RDATA, {32'hC0DE0009, 32'hC0DE0009});
    set_in(1'b1, 4'd9, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);
    step();
    check("flush_rvalid", 64'(RVALID), 64'd1);
    check("flush_rdata", RDATA, {32'hC0DE0009, 32'hC0DE0009});
    check("flush_ready_low", 64'(READY), 64'd0);
    run_sweep("flush", 1'b0);
    read_all("flush");

    // Reset asserted at sweep cycle 7
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    repeat (7) step();
    check("midsweep_ready_before", 64'(READY), 64'd0);
    RST_N = 1'b0;
    #1;
    check("midsweep_rst_ready", 64'(READY), 64'd0);
    check("midsweep_rst_init_done", 64'(INIT_DONE), 64'd0);
    step();
    RST_N = 1'b1;
    run_sweep("midsweep", 1'b0);
    read_all("midsweep");

    // Reset during RUN after writes, then a sweep with FLUSH poked mid-way
    set_in(1'b0, 4'd0, 2'b11, 4'd4, 4'hF, 32'h00000055, 1'b0);
    step();
    set_in(1'b1, 4'd4, 2'b00, 4'd0, 4'h0, 32'h0, 1'b0);
    step();
    check("run_rdata_4", RDATA, {32'h00000055, 32'h00000055});
    idle();
    RST_N = 1'b0;
    #1;
    check("runrst_ready", 64'(READY), 64'd0);
    check("runrst_rvalid", 64'(RVALID), 64'd0);
    check("runrst_rdata", RDATA, 64'd0);
    step();
    RST_N = 1'b1;
    run_sweep("runrst", 1'b1);
    read_all("runrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
